// File: rtl/node_mac_serial.sv
// rtl/node_mac_serial.sv - serial signed MAC neuron: bias, round, ReLU, saturate to DW bits.
// Optional NODE_LEAKY_RELU_EN gives negative sums a rounded slope of 1/8 instead of zero.
module node_mac_serial #(
  parameter int N_IN = 10,
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int FRAC = 6,
  parameter int ACCW = 23,
  parameter logic [N_IN*WW-1:0] WEIGHTS = 80'hD210FE1610FCE418F62C,
  parameter logic signed [ACCW-1:0] BIAS = -512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IN*DW-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  if (ACCW < DW + WW + $clog2(N_IN) + 1) begin : g_bad_accw
    $error("node_mac_serial: ACCW too small for N_IN/DW/WW");
  end

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);
  localparam logic signed [ACCW:0] HALF = (ACCW+1)'(2 ** (FRAC - 1));
  localparam logic signed [ACCW:0] MAXV = (ACCW+1)'(2 ** (DW - 1) - 1);
`ifdef NODE_LEAKY_RELU_EN
  localparam logic signed [ACCW:0] HALF_L = (ACCW+1)'(2 ** (FRAC + 2));
  localparam logic signed [ACCW:0] MINV   = (ACCW+1)'(-(2 ** (DW - 1)));
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N_IN*DW-1:0]      x_q, x_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic signed [DW-1:0]    x_cur;
  logic signed [WW-1:0]    w_cur;
  logic signed [DW+WW-1:0] prod;
  logic signed [ACCW:0]    acc_ext, r_pos;
  logic [DW-1:0]           act;
`ifdef NODE_LEAKY_RELU_EN
  logic signed [ACCW:0]    r_neg;
`endif

  always_comb begin
    x_cur   = x_q[int'(idx_q)*DW +: DW];
    w_cur   = WEIGHTS[int'(idx_q)*WW +: WW];
    prod    = x_cur * w_cur;
    acc_ext = (ACCW+1)'(acc_q);
    r_pos   = (acc_ext + HALF) >>> FRAC;
    act     = (r_pos > MAXV) ? MAXV[DW-1:0] : r_pos[DW-1:0];
`ifdef NODE_LEAKY_RELU_EN
    r_neg   = (acc_ext + HALF_L) >>> (FRAC + 3);
    if (acc_q < 0) act = (r_neg < MINV) ? MINV[DW-1:0] : r_neg[DW-1:0];
`else
    if (acc_q < 0) act = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready_q) begin
        x_d        = in_data;
        acc_d      = BIAS;
        idx_d      = '0;
        in_ready_d = 1'b0;
        state_d    = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        out_data_d  = act;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_node_mac_serial.sv
// tb/tb_node_mac_serial.sv - directed bench for node_mac_serial with default weights and bias.
// Honours NODE_LEAKY_RELU_EN for the negative-sum expectations.
module tb_node_mac_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [79:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  node_mac_serial dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] vec1(input int i, input logic [7:0] v);
    logic [79:0] r;
    r = '0;
    r[i*8 +: 8] = v;
    return r;
  endfunction

  // Wait for out_valid, then check latency and value; consumer is assumed ready.
  task automatic wait_result(input string tag, input logic [7:0] exp, input int exp_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
  endtask

  task automatic run(input string tag, input logic [79:0] din, input logic [7:0] exp);
    in_data  = din;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    in_data  = ~din;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_result(tag, exp, 11);
    tick;
    chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [79:0] v;
    logic [7:0]  exp_zero, exp_neg;
`ifdef NODE_LEAKY_RELU_EN
    exp_zero = 8'hFF;
    exp_neg  = 8'hFD;
`else
    exp_zero = 8'h00;
    exp_neg  = 8'h00;
`endif
    tick;
    tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    reset = 1'b1;
    tick;

    run("zeros", '0, exp_zero);
    run("x0_64", vec1(0, 8'd64), 8'd36);
    run("round_up", vec1(0, 8'd13), 8'd1);
    run("round_down", vec1(0, 8'd12), 8'd0);
    v = '0;
    v[0*8 +: 8] = 8'd127;
    v[2*8 +: 8] = 8'd127;
    v[5*8 +: 8] = 8'd127;
    v[6*8 +: 8] = 8'd127;
    v[8*8 +: 8] = 8'd127;
    run("saturate", v, 8'd127);
    run("x9_neg128", vec1(9, 8'h80), 8'd84);
    run("neg_sum", vec1(1, 8'd127), exp_neg);

    out_ready = 1'b0;
    in_data   = vec1(0, 8'd64);
    in_valid  = 1'b1;
    tick;
    in_valid  = 1'b0;
    in_data   = '1;
    wait_result("bp", 8'd36, 11);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_data", {24'd0, out_data}, 32'd36);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick;
    chk("bp_vdrop", {31'd0, out_valid}, 32'd0);
    chk("bp_rdy", {31'd0, in_ready}, 32'd1);
    run("bp_next", vec1(0, 8'd13), 8'd1);

    in_data  = vec1(0, 8'd127);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    reset = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_rdy", {31'd0, in_ready}, 32'd1);
    tick;
    reset = 1'b1;
    tick;
    run("post_rst", vec1(0, 8'd64), 8'd36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
